// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared state encoding and constants for the PWM capture block
package pwm_capture_pkg;
  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/pwm_input_conditioner.sv
// pwm_input_conditioner: resynchronises pwm_in, applies polarity and detects active edges
module pwm_input_conditioner
  import pwm_capture_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic polarity,
  input  logic pwm_in,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic s3;
  logic level;
  assign level = sync[SYNC_STAGES-1] ^ polarity;
  assign rise = level & ~s3;
  assign fall = ~level & s3;
  // synchroniser chain plus one history flop of the polarity-corrected level
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sync <= '0;
      s3 <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      s3 <= level;
    end
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an external PWM signal in timebase ticks
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     timebase,
  input  logic                     enable,
  input  logic                     polarity,
  input  logic                     pwm_in,
  input  logic [COUNTER_WIDTH-1:0] timeout_value,
  output logic [COUNTER_WIDTH-1:0] period_out,
  output logic [COUNTER_WIDTH-1:0] high_time_out,
  output logic                     data_valid,
  output logic                     timeout,
  output logic                     saturated
);
  state_t state;
  logic [COUNTER_WIDTH-1:0] counter, high_reg, count_next, count_start;
  logic pol, rise, fall, expired;
  assign count_start = COUNTER_WIDTH'(timebase);
  assign count_next = &counter ? counter : counter + count_start;
  assign expired = (timeout_value != '0) && (counter == timeout_value);
  pwm_input_conditioner u_cond (
    .clock    (clock),
    .reset    (reset),
    .polarity (pol),
    .pwm_in   (pwm_in),
    .rise     (rise),
    .fall     (fall)
  );
  // measurement FSM: enable dominates, then timeout, then edges; captures use the pre-increment count
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      counter <= '0;
      high_reg <= '0;
      period_out <= '0;
      high_time_out <= '0;
      data_valid <= 1'b0;
      timeout <= 1'b0;
      saturated <= 1'b0;
      pol <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      timeout <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        counter <= '0;
      end else
        case (state)
          IDLE: begin
            counter <= '0;
            pol <= polarity;
            saturated <= 1'b0;
            state <= ARM;
          end
          ARM: begin
            counter <= rise ? count_start : '0;
            state <= rise ? HIGH : ARM;
          end
          default:
            if (expired) begin
              timeout <= 1'b1;
              saturated <= 1'b0;
              counter <= '0;
              state <= ARM;
            end else if (state == HIGH) begin
              counter <= count_next;
              saturated <= saturated | (&count_next);
              if (fall) begin
                high_reg <= counter;
                state <= LOW;
              end
            end else if (rise) begin
              period_out <= counter;
              high_time_out <= high_reg;
              data_valid <= 1'b1;
              counter <= count_start;
              state <= HIGH;
            end else begin
              counter <= count_next;
              saturated <= saturated | (&count_next);
            end
        endcase
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed vector table plus hand sequences for latency, timeout, saturation and aborts
module tb_pwm_capture;
  import pwm_capture_pkg::*;
  logic clock = 1'b0;
  logic reset, timebase, enable, polarity, pwm_in;
  logic [15:0] timeout_value;
  logic [15:0] period16, high16;
  logic dv16, to16, sat16;
  logic [7:0] period8, high8;
  logic dv8, to8, sat8;
  int checks = 0, failures = 0;
  int div = 1, tcnt = 0;
  int nv = 0, nto = 0, nboth = 0, ncyc = 0, lastc = 0, gap_bad = 0, exp_gap = 0;
  int nv_before;
  logic [15:0] p0, h0;
  typedef struct {
    int   h;
    int   l;
    logic pol;
    int   d;
    int   ep;
    int   eh;
  } vec_t;
  vec_t vt[6];

  pwm_capture #(.COUNTER_WIDTH(16)) dut16 (
    .clock(clock), .reset(reset), .timebase(timebase), .enable(enable),
    .polarity(polarity), .pwm_in(pwm_in), .timeout_value(timeout_value),
    .period_out(period16), .high_time_out(high16), .data_valid(dv16),
    .timeout(to16), .saturated(sat16)
  );
  pwm_capture #(.COUNTER_WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .timebase(timebase), .enable(enable),
    .polarity(polarity), .pwm_in(pwm_in), .timeout_value(timeout_value[7:0]),
    .period_out(period8), .high_time_out(high8), .data_valid(dv8),
    .timeout(to8), .saturated(sat8)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    ncyc++;
    if ((dv16 && to16) || (dv8 && to8)) nboth++;
    if (to16) nto++;
    if (dv16) begin
      if (nv == 0) begin
        p0 = period16;
        h0 = high16;
      end else if (exp_gap != 0 && ncyc - lastc != exp_gap) gap_bad++;
      lastc = ncyc;
      nv++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic p);
    pwm_in = p;
    timebase = (tcnt % div) == 0;
    tcnt++;
    @(negedge clock);
  endtask

  task automatic wave(input int h, input int l, input logic pol, input int n);
    for (int k = 0; k < n; k++) begin
      repeat (h) cyc(~pol);
      repeat (l) cyc(pol);
    end
  endtask

  task automatic restart(input logic pol, input int d);
    enable = 1'b0;
    polarity = pol;
    repeat (3) cyc(pol);
    div = d;
    tcnt = 0;
    enable = 1'b1;
    repeat (4) cyc(pol);
    nv = 0;
    nto = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{3, 7, 1'b0, 1, 10, 3};
    vt[1] = '{20, 20, 1'b0, 4, 10, 5};
    vt[2] = '{4, 6, 1'b1, 1, 10, 4};
    vt[3] = '{5, 5, 1'b0, 1, 10, 5};
    vt[4] = '{1, 2, 1'b0, 1, 3, 1};
    vt[5] = '{6, 10, 1'b0, 2, 8, 3};
    reset = 1'b1;
    enable = 1'b0;
    polarity = 1'b0;
    pwm_in = 1'b0;
    timebase = 1'b0;
    timeout_value = '0;
    repeat (3) @(negedge clock);
    check("reset outputs16", {period16, high16, dv16, to16, sat16}, 0);
    check("reset outputs8", {period8, high8, dv8, to8, sat8}, 0);
    check("reset state", dut16.state, IDLE);
    reset = 1'b0;

    restart(1'b0, 1);
    exp_gap = 0;
    wave(3, 7, 1'b0, 1);
    cyc(1'b1);
    check("latency edge1 dv", dv16, 0);
    cyc(1'b1);
    check("latency edge2 dv", dv16, 0);
    cyc(1'b1);
    check("latency edge3 dv", dv16, 1);
    check("latency period", period16, 10);
    check("latency high", high16, 3);
    cyc(1'b0);
    check("dv single cycle", dv16, 0);
    repeat (6) cyc(1'b0);

    for (int i = 0; i < 6; i++) begin
      restart(vt[i].pol, vt[i].d);
      exp_gap = vt[i].h + vt[i].l;
      gap_bad = 0;
      wave(vt[i].h, vt[i].l, vt[i].pol, 3);
      repeat (6) cyc(vt[i].pol);
      check($sformatf("v%0d dv count", i), nv, 2);
      check($sformatf("v%0d period", i), p0, vt[i].ep);
      check($sformatf("v%0d high", i), h0, vt[i].eh);
      check($sformatf("v%0d dv spacing", i), gap_bad, 0);
      check($sformatf("v%0d period8", i), period8, vt[i].ep);
      check($sformatf("v%0d high8", i), high8, vt[i].eh);
    end

    polarity = 1'b0;
    restart(1'b0, 1);
    exp_gap = 0;
    timeout_value = 16'd50;
    repeat (52) cyc(1'b1);
    check("timeout early", to16, 0);
    cyc(1'b1);
    check("timeout pulse16", to16, 1);
    check("timeout pulse8", to8, 1);
    check("timeout no dv", dv16, 0);
    cyc(1'b1);
    check("timeout single", to16, 0);
    check("timeout state arm", dut16.state, ARM);
    check("timeout hold period", period16, 8);
    check("timeout hold high", high16, 3);
    check("timeout no dv count", nv, 0);
    exp_gap = 10;
    gap_bad = 0;
    repeat (7) cyc(1'b0);
    wave(3, 7, 1'b0, 3);
    repeat (6) cyc(1'b0);
    check("resume dv count", nv, 2);
    check("resume period", p0, 10);
    check("resume high", h0, 3);
    check("resume spacing", gap_bad, 0);
    check("timeout pulse count", nto, 1);

    timeout_value = '0;
    restart(1'b0, 1);
    exp_gap = 0;
    wave(3, 300, 1'b0, 1);
    wave(3, 5, 1'b0, 1);
    check("sat dv count", nv, 1);
    check("sat period16", p0, 303);
    check("sat high16", h0, 3);
    check("sat period8", period8, 255);
    check("sat high8", high8, 3);
    check("sat flag8", sat8, 1);
    check("sat flag16", sat16, 0);

    repeat (4) cyc(1'b1);
    nv_before = nv;
    enable = 1'b0;
    cyc(1'b1);
    check("abort state idle", dut16.state, IDLE);
    check("abort sat holds", sat8, 1);
    check("abort period holds", period16, 8);
    check("abort high holds", high16, 3);
    wave(3, 7, 1'b0, 2);
    check("abort no dv", nv, nv_before);
    check("abort no timeout", nto, 1'b0);
    check("abort still idle", dut16.state, IDLE);

    restart(1'b0, 1);
    wave(3, 7, 1'b0, 3);
    repeat (4) cyc(1'b1);
    check("pre-reset period", period16, 10);
    #2 reset = 1'b1;
    #1;
    check("midreset outputs16", {period16, high16, dv16, to16, sat16}, 0);
    check("midreset outputs8", {period8, high8, dv8, to8, sat8}, 0);
    check("midreset state", dut16.state, IDLE);
    @(negedge clock);
    reset = 1'b0;
    nv_before = nv;
    repeat (10) cyc(1'b0);
    check("post-reset no dv", nv, nv_before);
    check("dv and timeout never together", nboth, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_capture.md
# pwm_capture

Input-capture block that measures an external PWM waveform, the receive-side counterpart of the PWM generator's counter. It resynchronises the incoming signal, counts timebase ticks between edges, and reports period and high time once per full cycle with a single-cycle valid strobe. It sits in the controls tree beside the PWM generator and feeds measured period and duty to the control loop or to a register bank.

## Interface
- COUNTER_WIDTH, 16, width of the tick counter and all measurement outputs.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- timebase  in  1  tick enable; the counter advances only in cycles where this is 1.
- enable  in  1  capture run; 0 forces IDLE.
- polarity  in  1  0: the active phase is the high level of pwm_in; 1: pwm_in is inverted before processing. Latched on IDLE→ARM.
- pwm_in  in  1  asynchronous PWM input.
- timeout_value  in  COUNTER_WIDTH  tick count that aborts a measurement; 0 disables the timeout.
- period_out  out  COUNTER_WIDTH  ticks between consecutive active rising edges.
- high_time_out  out  COUNTER_WIDTH  ticks from the active rising edge to the falling edge.
- data_valid  out  1  one-cycle strobe; period_out and high_time_out were updated this cycle.
- timeout  out  1  one-cycle strobe; a measurement was aborted.
- saturated  out  1  sticky; the counter hit all-ones since the last ARM entry.

## Operation
- Input path: two-flop synchroniser (s1, s2), then XOR with the latched polarity, then a history flop s3.
  - rise = s2' & ~s3.
  - fall = ~s2' & s3.
- IDLE: counter cleared, no strobes. Move to ARM when enable=1.
- ARM: wait for rise; fall is ignored. On rise, set counter ← timebase ? 1 : 0 and go to HIGH.
- HIGH: counter += timebase.
  - On fall: capture high_reg ← counter and go to LOW. The counter keeps running.
- LOW: counter += timebase.
  - On rise: period_out ← counter, high_time_out ← high_reg, data_valid=1, counter ← timebase ? 1 : 0, stay in the measuring loop via HIGH.
- Counter saturates at all-ones and does not wrap. Reaching all-ones sets saturated.
- Timeout: in HIGH or LOW, if timeout_value≠0 and counter==timeout_value, pulse timeout and go to ARM. No data_valid is produced. Outputs keep their old values.
- enable=0 in any state: go to IDLE next cycle. It dominates simultaneous edges and timeout. Outputs hold, saturated holds.
- A rise on the same cycle that timeout fires: the timeout wins, and the rise is not used to re-arm.
- Captured values use the counter value before that cycle's increment.

## Timing
- Reset values:
  - period_out = 0, high_time_out = 0.
  - data_valid = 0, timeout = 0, saturated = 0.
  - state = IDLE; s1, s2, s3 = 0; latched polarity = 0.
- Latency: data_valid is high in the cycle after the 3rd clock edge following the first edge that samples the new pwm_in level (2 synchroniser stages plus 1 registered output).
- data_valid and timeout are single-cycle and never asserted together.
- There is no back-pressure. The consumer samples on data_valid. Outputs are stable until the next data_valid.
- The first full period after ARM yields the first data_valid. The partial period before the first rise is discarded.
- Reset asserted mid-measurement clears everything immediately. No strobe is emitted.

## Structure
- Package pwm_capture_pkg holds:
  - the state enum {IDLE, ARM, HIGH, LOW};
  - localparam SYNC_STAGES = 2.
- Sub-module pwm_input_conditioner contains the synchroniser, polarity XOR, history flop and rise/fall outputs. Everything else lives in pwm_capture.

## Test plan
- Baseline: timebase=1, enable=1, polarity=0, pwm_in high 3 / low 7 cycles, repeated.
  - Expected: the first data_valid comes after the second rising edge, with period_out=10 and high_time_out=3.
  - Expected: data_valid repeats every 10 cycles.
- Prescaled timebase: timebase active every 4th cycle, pwm_in high 20 / low 20.
  - Expected: period_out=10, high_time_out=5.
- Inverted polarity: polarity=1, pwm_in low 4 / high 6.
  - Expected: period_out=10, high_time_out=4.
- Timeout: timeout_value=50, pwm_in stuck high after a rise.
  - Expected: timeout pulses once 50 ticks after the rise, the block returns to ARM, and data_valid stays 0.
  - Then resume the 3/7 waveform. Expected: valid data resumes after two rises.
- Saturation and abort:
  - COUNTER_WIDTH=8, timeout_value=0, pwm_in held low for 300 cycles after a rise. Expected: saturated=1 and the counter is held at 255.
  - Deassert enable mid-HIGH. Expected: IDLE next cycle and no strobes.
  - Assert reset mid-measurement. Expected: all outputs are 0.
